// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ------------------------------------------------------------------------
// fifo_stream_reader: drains a FWFT async-FIFO read port into a 2-entry
// valid/ready stream with flush. word_count built only with READER_STATS_EN.
// Rev 1.0
// ------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_read_en,
  input  logic             flush,
  output logic             flush_busy,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      word_count
);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [1:0]       r_rst_sync;
  logic [1:0]       r_occ, w_occ_next;
  logic [WIDTH-1:0] r_buf0, r_buf1;
  logic [WIDTH-1:0] w_buf0_next, w_buf1_next;
  logic             w_pop, w_xfer;

  // Reset assertion is immediate; release reaches the pop logic two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_comb begin
    fifo_read_en = 1'b0;
    if (r_rst_sync[1]) begin
      if (r_state == FLUSH) fifo_read_en = !fifo_empty;
      else                  fifo_read_en = !fifo_empty && (r_occ < 2'd2);
    end
  end

  assign m_valid    = (r_state == RUN) && (r_occ != 2'd0);
  assign flush_busy = (r_state == FLUSH);
  assign m_data     = r_buf0;
  assign w_pop      = fifo_read_en && !fifo_empty;
  assign w_xfer     = m_valid && m_ready;

  always_comb begin
    w_state_next = r_state;
    w_occ_next   = r_occ;
    w_buf0_next  = r_buf0;
    w_buf1_next  = r_buf1;
    case (r_state)
      RUN: begin
        if (flush) begin
          // Any word popped on this edge is discarded along with the buffer.
          w_state_next = FLUSH;
          w_occ_next   = 2'd0;
        end else begin
          case (r_occ)
            2'd0: begin
              if (w_pop) begin
                w_buf0_next = fifo_read_data;
                w_occ_next  = 2'd1;
              end
            end
            2'd1: begin
              if (w_pop && w_xfer) begin
                w_buf0_next = fifo_read_data;
              end else if (w_xfer) begin
                w_occ_next = 2'd0;
              end else if (w_pop) begin
                w_buf1_next = fifo_read_data;
                w_occ_next  = 2'd2;
              end
            end
            default: begin
              if (w_xfer) begin
                w_buf0_next = r_buf1;
                w_occ_next  = 2'd1;
              end
            end
          endcase
        end
      end
      FLUSH: begin
        if (fifo_empty) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_occ   <= 2'd0;
      r_buf0  <= '0;
      r_buf1  <= '0;
    end else begin
      r_state <= w_state_next;
      r_occ   <= w_occ_next;
      r_buf0  <= w_buf0_next;
      r_buf1  <= w_buf1_next;
    end
  end

`ifdef READER_STATS_EN
  logic [15:0] r_word_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_word_count <= 16'd0;
    else if (w_xfer) r_word_count <= r_word_count + 16'd1;
  end

  assign word_count = r_word_count;
`else
  assign word_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// tb_fifo_stream_reader: directed + random stimulus for fifo_stream_reader,
// checked against a queue-level model of the FIFO, buffer and flush rules.
module tb_fifo_stream_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
`ifdef READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush   = 1'b0;
  logic             m_ready = 1'b0;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_read_data;
  logic             fifo_read_en;
  logic             flush_busy;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [15:0]      word_count;

  // Source FIFO: stimulus owns wr_ptr, the FIFO process owns rd_ptr.
  logic [WIDTH-1:0] src_mem [DEPTH];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  bit               pop_pending = 1'b0;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_read_data = src_mem[rd_ptr[9:0]];

  // Reference model state
  logic [WIDTH-1:0] exp_q [$];
  bit               flushing   = 1'b0;
  int               sync_cnt   = 0;
  logic [15:0]      exp_cnt    = 16'd0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  int               n_cmp      = 0;
  int               n_err      = 0;

  fifo_stream_reader #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .flush          (flush),
    .flush_busy     (flush_busy),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .word_count     (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (pop_pending) rd_ptr = rd_ptr + 1;
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples 2 time units after each falling edge and
  // advances the model for the coming rising edge.
  initial begin
    bit               exp_valid;
    bit               exp_ren;
    logic [WIDTH-1:0] exp_word;
    logic [15:0]      exp_wc;
    forever begin
      @(negedge clk or negedge reset_n);
      if (clk) begin
        #1;
        chk("async_rst_m_valid", {31'd0, m_valid}, 0);
        chk("async_rst_read_en", {31'd0, fifo_read_en}, 0);
        chk("async_rst_flush_busy", {31'd0, flush_busy}, 0);
        chk("async_rst_m_data", m_data, 0);
        chk("async_rst_word_count", {16'd0, word_count}, 0);
        pop_pending = 1'b0;
      end else begin
        #2;
        if (!reset_n) begin
          chk("rst_m_valid", {31'd0, m_valid}, 0);
          chk("rst_read_en", {31'd0, fifo_read_en}, 0);
          chk("rst_flush_busy", {31'd0, flush_busy}, 0);
          chk("rst_m_data", m_data, 0);
          chk("rst_word_count", {16'd0, word_count}, 0);
          exp_q.delete();
          flushing    = 1'b0;
          sync_cnt    = 0;
          exp_cnt     = 16'd0;
          prev_stall  = 1'b0;
          pop_pending = 1'b0;
        end else begin
          exp_valid = !flushing && (exp_q.size() != 0);
          exp_ren   = (sync_cnt >= 2) && !fifo_empty && (flushing || exp_q.size() < 2);
          exp_wc    = STATS ? exp_cnt : 16'd0;
          chk("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
          chk("fifo_read_en", {31'd0, fifo_read_en}, {31'd0, exp_ren});
          chk("flush_busy", {31'd0, flush_busy}, {31'd0, flushing});
          chk("word_count", {16'd0, word_count}, {16'd0, exp_wc});
          if (prev_stall && m_valid) chk("hold_m_data", m_data, prev_data);
          prev_stall = m_valid && !m_ready;
          prev_data  = m_data;
          if (exp_valid && m_ready) begin
            exp_word = exp_q.pop_front();
            chk("stream_data", m_data, exp_word);
            exp_cnt = exp_cnt + 16'd1;
          end
          pop_pending = fifo_read_en && !fifo_empty;
          if (!flushing) begin
            if (flush) begin
              exp_q.delete();
              flushing = 1'b1;
            end else if (pop_pending) begin
              exp_q.push_back(fifo_read_data);
            end
          end else if (fifo_empty) begin
            flushing = 1'b0;
          end
          if (sync_cnt < 2) sync_cnt++;
        end
      end
    end
  end

  task automatic next();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) next();
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    src_mem[wr_ptr[9:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    run(3);
    reset_n = 1'b1;

    // Three words streamed with m_ready held high
    m_ready = 1'b1;
    push(32'hA1); push(32'hB2); push(32'hC3);
    run(8);

    // Backpressure: only two words may be popped while m_ready is low
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h100 + i);
    run(6);
    m_ready = 1'b1;
    run(10);

    // Flush with a full buffer and three words still queued
    m_ready = 1'b0;
    push(32'h11); push(32'h22);
    run(4);
    push(32'h33); push(32'h44); push(32'h66);
    flush = 1'b1;
    run(8);
    push(32'h55);
    m_ready = 1'b1;
    run(5);

    // Flush on the same edge as an accepted transfer
    m_ready = 1'b0;
    push(32'h201); push(32'h202);
    run(3);
    m_ready = 1'b1;
    flush = 1'b1;
    run(4);

    // Asynchronous reset between edges with one word buffered
    m_ready = 1'b0;
    push(32'h77);
    run(3);
    @(posedge clk);
    #2 reset_n = 1'b0;
    run(2);
    push(32'h88);
    run(2);
    reset_n = 1'b1;
    m_ready = 1'b1;
    run(6);

    // Random traffic, backpressure and flushes
    for (int i = 0; i < 3000; i++) begin
      next();
      m_ready = ($urandom_range(0, 3) != 0);
      if (($urandom_range(0, 1) == 1) && ((wr_ptr - rd_ptr) < 64)) push($urandom);
      if ($urandom_range(0, 49) == 0) flush = 1'b1;
    end

    // 65537 transfers from reset: counter wraps to 1
    next();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      push($urandom);
      next();
    end
    run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
